if_id_decode_reg: RTL and testbench



---
 rtl/mips_pkg.sv | 37 +++
 rtl/eop_decode.sv | 39 +++
 rtl/if_id_decode_reg.sv | 103 ++++++++++
 tb/tb_if_id_decode_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS opcode and immediate-extension (EOp) definitions used by the
// IF/ID register, the immediate extender and the control unit.
package mips_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // EOp select for ext: zero-extend, sign-extend, upper-half, branch offset
  localparam logic [1:0] EOP_ZERO = 2'd0;
  localparam logic [1:0] EOP_SIGN = 2'd1;
  localparam logic [1:0] EOP_LUI  = 2'd2;
  localparam logic [1:0] EOP_BR   = 2'd3;

  localparam int INSTR_W = 32;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/eop_decode.sv
// Combinational opcode pre-decode: selects the ext mode and flags whether the
// instruction consumes the extended immediate at all.
module eop_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  output logic [1:0] eop,
  output logic       imm_used
);

  // Opcode to EOp / imm_used lookup
  always_comb begin
    eop      = EOP_ZERO;
    imm_used = 1'b0;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: begin
        eop      = EOP_ZERO;
        imm_used = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
        eop      = EOP_SIGN;
        imm_used = 1'b1;
      end
      OP_LUI: begin
        eop      = EOP_LUI;
        imm_used = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        eop      = EOP_BR;
        imm_used = 1'b1;
      end
      default: begin
        eop      = EOP_ZERO;
        imm_used = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/if_id_decode_reg.sv
// IF/ID pipeline register: captures instruction and PC+4, registers the
// pre-decoded EOp for ext, and counts stall cycles (saturating).
module if_id_decode_reg
  import mips_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_f,
  input  logic [PC_W-1:0]   pc4_f,
  input  logic              stall,
  input  logic              flush,
  output logic [31:0]       instr_d,
  output logic [PC_W-1:0]   pc4_d,
  output logic              valid_d,
  output logic [4:0]        rs_d,
  output logic [4:0]        rt_d,
  output logic [4:0]        rd_d,
  output logic [4:0]        shamt_d,
  output logic [15:0]       imm_d,
  output logic [1:0]        eop_d,
  output logic              imm_used_d,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]       eop_f_s;
  logic             imm_used_f_s;
  logic             hold_s;
  logic             cnt_sat_s;

  logic [31:0]      instr_r;
  logic [PC_W-1:0]  pc4_r;
  logic             valid_r;
  logic [1:0]       eop_r;
  logic             imm_used_r;
  logic [CNT_W-1:0] stall_cnt_r;

  eop_decode u_eop_decode (
    .op       (opcode_of(instr_f)),
    .eop      (eop_f_s),
    .imm_used (imm_used_f_s)
  );

  // flush outranks stall, so a stall cycle is counted only when not flushed
  assign hold_s    = stall & ~flush;
  assign cnt_sat_s = (stall_cnt_r == {CNT_W{1'b1}});

  // Pipeline register update: flush > stall > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r    <= 32'd0;
      pc4_r      <= {PC_W{1'b0}};
      valid_r    <= 1'b0;
      eop_r      <= EOP_ZERO;
      imm_used_r <= 1'b0;
    end else if (flush) begin
      instr_r    <= 32'd0;
      pc4_r      <= {PC_W{1'b0}};
      valid_r    <= 1'b0;
      eop_r      <= EOP_ZERO;
      imm_used_r <= 1'b0;
    end else if (stall) begin
      instr_r    <= instr_r;
      pc4_r      <= pc4_r;
      valid_r    <= valid_r;
      eop_r      <= eop_r;
      imm_used_r <= imm_used_r;
    end else begin
      instr_r    <= instr_f;
      pc4_r      <= pc4_f;
      valid_r    <= 1'b1;
      eop_r      <= eop_f_s;
      imm_used_r <= imm_used_f_s;
    end
  end

  // Saturating stall-cycle counter, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (hold_s && !cnt_sat_s) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign instr_d    = instr_r;
  assign pc4_d      = pc4_r;
  assign valid_d    = valid_r;
  assign eop_d      = eop_r;
  assign imm_used_d = imm_used_r;
  assign stall_cnt  = stall_cnt_r;

  assign rs_d    = instr_r[25:21];
  assign rt_d    = instr_r[20:16];
  assign rd_d    = instr_r[15:11];
  assign shamt_d = instr_r[10:6];
  assign imm_d   = instr_r[15:0];

endmodule

// File: tb/tb_if_id_decode_reg.sv
// Self-checking bench for if_id_decode_reg: opcode-table model compared every
// cycle, plus literal checks of the directed scenarios.
module tb_if_id_decode_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_f = 32'd0;
  logic [31:0] pc4_f = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] instr_d, pc4_d;
  logic        valid_d, imm_used_d;
  logic [4:0]  rs_d, rt_d, rd_d, shamt_d;
  logic [15:0] imm_d;
  logic [1:0]  eop_d;
  logic [15:0] stall_cnt;

  logic [31:0] s_instr_d, s_pc4_d;
  logic        s_valid_d, s_imm_used_d;
  logic [4:0]  s_rs_d, s_rt_d, s_rd_d, s_shamt_d;
  logic [15:0] s_imm_d;
  logic [1:0]  s_eop_d;
  logic [3:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  if_id_decode_reg #(.PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr_f(instr_f), .pc4_f(pc4_f),
    .stall(stall), .flush(flush), .instr_d(instr_d), .pc4_d(pc4_d),
    .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .shamt_d(shamt_d), .imm_d(imm_d), .eop_d(eop_d),
    .imm_used_d(imm_used_d), .stall_cnt(stall_cnt)
  );

  if_id_decode_reg #(.PC_W(32), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .instr_f(instr_f), .pc4_f(pc4_f),
    .stall(stall), .flush(flush), .instr_d(s_instr_d), .pc4_d(s_pc4_d),
    .valid_d(s_valid_d), .rs_d(s_rs_d), .rt_d(s_rt_d), .rd_d(s_rd_d),
    .shamt_d(s_shamt_d), .imm_d(s_imm_d), .eop_d(s_eop_d),
    .imm_used_d(s_imm_used_d), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Opcode table: the decode rules written out as data
  logic [1:0] tab_eop [64];
  logic       tab_used [64];
  initial begin
    for (int i = 0; i < 64; i++) begin
      tab_eop[i]  = 2'd0;
      tab_used[i] = 1'b0;
    end
    tab_used[12] = 1'b1; tab_used[13] = 1'b1; tab_used[14] = 1'b1;
    tab_eop[8]  = 2'd1; tab_eop[9]  = 2'd1; tab_eop[10] = 2'd1;
    tab_eop[11] = 2'd1; tab_eop[35] = 2'd1; tab_eop[43] = 2'd1;
    tab_used[8] = 1'b1; tab_used[9] = 1'b1; tab_used[10] = 1'b1;
    tab_used[11] = 1'b1; tab_used[35] = 1'b1; tab_used[43] = 1'b1;
    tab_eop[15] = 2'd2; tab_used[15] = 1'b1;
    tab_eop[4] = 2'd3; tab_eop[5] = 2'd3; tab_eop[6] = 2'd3;
    tab_eop[7] = 2'd3; tab_eop[1] = 2'd3;
    tab_used[4] = 1'b1; tab_used[5] = 1'b1; tab_used[6] = 1'b1;
    tab_used[7] = 1'b1; tab_used[1] = 1'b1;
  end

  // Behavioural model of the register contents
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc4 = 32'd0;
  logic        m_valid = 1'b0;
  int          m_stalls = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0; m_stalls <= 0;
    end else if (flush) begin
      m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
    end else if (stall) begin
      m_stalls <= m_stalls + 1;
    end else begin
      m_instr <= instr_f; m_pc4 <= pc4_f; m_valid <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, on the inactive edge
  always @(negedge clk) begin
    int op;
    op = int'(m_instr >> 26);
    chk("instr_d", 64'(instr_d), 64'(m_instr));
    chk("pc4_d", 64'(pc4_d), 64'(m_pc4));
    chk("valid_d", 64'(valid_d), 64'(m_valid));
    chk("rs_d", 64'(rs_d), 64'((m_instr >> 21) & 32'h1F));
    chk("rt_d", 64'(rt_d), 64'((m_instr >> 16) & 32'h1F));
    chk("rd_d", 64'(rd_d), 64'((m_instr >> 11) & 32'h1F));
    chk("shamt_d", 64'(shamt_d), 64'((m_instr >> 6) & 32'h1F));
    chk("imm_d", 64'(imm_d), 64'(m_instr & 32'hFFFF));
    chk("eop_d", 64'(eop_d), 64'(tab_eop[op]));
    chk("imm_used_d", 64'(imm_used_d), 64'(tab_used[op]));
    chk("stall_cnt", 64'(stall_cnt), 64'((m_stalls > 65535) ? 65535 : m_stalls));
    chk("stall_cnt_w4", 64'(s_stall_cnt), 64'((m_stalls > 15) ? 15 : m_stalls));
    chk("instr_d_w4", 64'(s_instr_d), 64'(m_instr));
  end

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic s, input logic f);
    instr_f = i; pc4_f = p; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(valid_d), 64'd0);
    chk("reset_instr", 64'(instr_d), 64'd0);
    reset = 1'b0;

    drive(32'h2008FFFC, 32'h3004, 1'b0, 1'b0);
    chk("addi_valid", 64'(valid_d), 64'd1);
    chk("addi_eop", 64'(eop_d), 64'd1);
    chk("addi_imm", 64'(imm_d), 64'hFFFC);
    chk("addi_rt", 64'(rt_d), 64'd8);
    chk("addi_pc4", 64'(pc4_d), 64'h3004);

    drive(32'h3421ABCD, 32'h3008, 1'b0, 1'b0);
    chk("ori_eop", 64'(eop_d), 64'd0);
    chk("ori_used", 64'(imm_used_d), 64'd1);
    drive(32'h3C011234, 32'h300C, 1'b0, 1'b0);
    chk("lui_eop", 64'(eop_d), 64'd2);
    drive(32'h1022FFFF, 32'h3010, 1'b0, 1'b0);
    chk("beq_eop", 64'(eop_d), 64'd3);
    drive(32'h01095020, 32'h3014, 1'b0, 1'b0);
    chk("add_eop", 64'(eop_d), 64'd0);
    chk("add_used", 64'(imm_used_d), 64'd0);
    chk("add_rd", 64'(rd_d), 64'd10);

    drive(32'h8C220004, 32'h3018, 1'b0, 1'b0);
    drive(32'h11111111, 32'h301C, 1'b1, 1'b0);
    drive(32'h22222222, 32'h3020, 1'b1, 1'b0);
    drive(32'h33333333, 32'h3024, 1'b1, 1'b0);
    chk("stall_instr", 64'(instr_d), 64'h8C220004);
    chk("stall_eop", 64'(eop_d), 64'd1);
    chk("stall_cnt3", 64'(stall_cnt), 64'd3);

    drive(32'h44444444, 32'h3028, 1'b1, 1'b1);
    chk("flush_instr", 64'(instr_d), 64'd0);
    chk("flush_valid", 64'(valid_d), 64'd0);
    chk("flush_cnt", 64'(stall_cnt), 64'd3);

    for (int k = 0; k < 64; k++) begin
      logic [31:0] w;
      w = $urandom;
      w[31:26] = k[5:0];
      drive(w, 32'(k * 4), 1'b0, 1'b0);
    end

    // Reset asserted mid-stall, between edges
    drive(32'h2008FFFC, 32'h4000, 1'b0, 1'b0);
    drive(32'h55555555, 32'h4004, 1'b1, 1'b0);
    drive(32'h66666666, 32'h4008, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_instr", 64'(instr_d), 64'd0);
    chk("async_rst_valid", 64'(valid_d), 64'd0);
    chk("async_rst_cnt", 64'(stall_cnt), 64'd0);
    instr_f = 32'h3C011234; pc4_f = 32'h40; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_instr", 64'(instr_d), 64'h3C011234);
    chk("post_rst_valid", 64'(valid_d), 64'd1);
    chk("post_rst_eop", 64'(eop_d), 64'd2);

    for (int k = 0; k < 20; k++) drive(32'(k), 32'h5000, 1'b1, 1'b0);
    chk("sat_cnt_w4", 64'(s_stall_cnt), 64'd15);
    chk("sat_cnt_w16", 64'(stall_cnt), 64'd20);
    drive(32'h0, 32'h0, 1'b1, 1'b0);
    chk("sat_hold_w4", 64'(s_stall_cnt), 64'd15);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
